// File: rtl/ucaspian_pkg.sv
// Shared widths, synapse entry layout and walker state encoding for the uCaspian synapse block.
package ucaspian_pkg;
  localparam int SYN_ADDR_W    = 12;
  localparam int NEURON_ADDR_W = 8;
  localparam int WEIGHT_W      = 8;
  localparam int ENTRY_W       = WEIGHT_W + NEURON_ADDR_W;
  localparam int SYN_DEPTH     = 1 << SYN_ADDR_W;

  // Weight occupies the upper byte of a RAM word, target neuron the lower byte.
  typedef struct packed {
    logic [WEIGHT_W-1:0]      weight;
    logic [NEURON_ADDR_W-1:0] target;
  } syn_entry_t;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WALK  = 2'd2
  } syn_state_t;
endpackage

// File: rtl/ucaspian_synapse_if.sv
// Range request (syn_*) and dendrite output (dend_*) handshakes of the synapse block.
interface ucaspian_synapse_if;
  logic [ucaspian_pkg::SYN_ADDR_W-1:0]    syn_start;
  logic [ucaspian_pkg::SYN_ADDR_W-1:0]    syn_end;
  logic                                   syn_vld;
  logic                                   syn_rdy;
  logic [ucaspian_pkg::NEURON_ADDR_W-1:0] dend_addr;
  logic [ucaspian_pkg::WEIGHT_W-1:0]      dend_weight;
  logic                                   dend_vld;
  logic                                   dend_rdy;

  modport master (
    output syn_start, syn_end, syn_vld, dend_rdy,
    input  syn_rdy, dend_addr, dend_weight, dend_vld
  );

  modport slave (
    input  syn_start, syn_end, syn_vld, dend_rdy,
    output syn_rdy, dend_addr, dend_weight, dend_vld
  );
endinterface

// File: rtl/ucaspian_synapse_ram.sv
// Synapse store: 4096 x 16 simple dual-port RAM, one write port and one registered read port.
module dp_ram_16x4096
  import ucaspian_pkg::*;
(
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [SYN_ADDR_W-1:0] i_waddr,
  input  logic [ENTRY_W-1:0]    i_wdata,
  input  logic                  i_re,
  input  logic [SYN_ADDR_W-1:0] i_raddr,
  output logic [ENTRY_W-1:0]    o_rdata
);
  logic [ENTRY_W-1:0] r_mem [SYN_DEPTH];
  logic [ENTRY_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ucaspian_synapse.sv
// Synapse range walker: reads one RAM entry per cycle and streams (target, weight) through a skid buffer.
// Optional build macro UCASPIAN_SYN_SKIP_ZERO_EN drops zero-weight entries from the output stream.
module ucaspian_synapse #(
  parameter int SYN_ADDR_W    = 12,
  parameter int NEURON_ADDR_W = 8,
  parameter int WEIGHT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_act,
  input  logic                  clear_config,
  output logic                  clear_done,
  input  logic [SYN_ADDR_W-1:0] config_addr,
  input  logic [WEIGHT_W-1:0]   config_value,
  input  logic [2:0]            config_byte,
  input  logic                  config_enable,
  input  logic                  next_step,
  output logic                  step_done,
  ucaspian_synapse_if.slave     bus
);
  typedef ucaspian_pkg::syn_entry_t entry_t;
  typedef ucaspian_pkg::syn_state_t state_t;

  state_t                r_state;
  logic [SYN_ADDR_W-1:0] r_cur;
  logic [SYN_ADDR_W-1:0] r_end;
  logic [SYN_ADDR_W-1:0] r_sweep;
  logic                  r_sweep_done;
  entry_t                r_stage;
  logic                  r_rd_vld;
  entry_t                r_buf [2];
  logic [1:0]            r_buf_cnt;
  entry_t                r_dend;
  logic                  r_dend_vld;
  logic                  r_clear_done;
  logic                  r_step_done;

  logic                                w_handshake;
  logic                                w_issue;
  logic                                w_land;
  logic                                w_out_load;
  logic                                w_pop;
  logic                                w_push;
  logic [1:0]                          w_wr_idx;
  logic [WEIGHT_W+NEURON_ADDR_W-1:0]   w_rd_data;
  entry_t                              w_rd_entry;
  logic                                w_we;
  logic [SYN_ADDR_W-1:0]               w_waddr;
  logic [WEIGHT_W+NEURON_ADDR_W-1:0]   w_wdata;
  logic                                w_unused_next_step;

  assign w_unused_next_step = next_step;

  assign bus.syn_rdy = reset && (r_state == ucaspian_pkg::ST_IDLE) && enable
                       && !clear_config && !clear_act;
  assign w_handshake = bus.syn_vld && bus.syn_rdy;

  // Buffer occupancy plus the read sitting in the RAM register must leave room for one more.
  assign w_issue = (r_state == ucaspian_pkg::ST_WALK) && enable && !clear_config
                   && !clear_act && !config_enable
                   && ((3'(r_buf_cnt) + 3'(r_rd_vld)) < 3'd2);

  assign w_rd_entry = entry_t'(w_rd_data);

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign w_land = r_rd_vld && (w_rd_entry.weight != '0);
`else
  assign w_land = r_rd_vld;
`endif

  assign w_out_load = !r_dend_vld || bus.dend_rdy;
  assign w_pop      = w_out_load && (r_buf_cnt != 2'd0);
  assign w_push     = w_land && !(w_out_load && (r_buf_cnt == 2'd0));
  assign w_wr_idx   = r_buf_cnt - 2'(w_pop);

  // Write port: the clear sweep owns it while clear_config is high, otherwise config byte 3.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sweep;
    w_wdata = '0;
    if (clear_config) begin
      w_we = (r_state == ucaspian_pkg::ST_CLEAR) && !r_sweep_done;
    end else if (!clear_act && config_enable && (config_byte == 3'd3)) begin
      w_we    = 1'b1;
      w_waddr = config_addr;
      w_wdata = {r_stage.weight, config_value};
    end
  end

  dp_ram_16x4096 u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_issue),
    .i_raddr (r_cur),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ucaspian_pkg::ST_IDLE;
      r_cur        <= '0;
      r_end        <= '0;
      r_sweep      <= '0;
      r_sweep_done <= 1'b0;
      r_stage      <= '0;
      r_rd_vld     <= 1'b0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_buf_cnt    <= '0;
      r_dend       <= '0;
      r_dend_vld   <= 1'b0;
      r_clear_done <= 1'b0;
      r_step_done  <= 1'b0;
    end else begin
      r_step_done <= (r_state == ucaspian_pkg::ST_IDLE) && !bus.syn_vld
                     && (r_buf_cnt == 2'd0) && !r_rd_vld && !r_dend_vld;
      if (clear_config) begin
        r_rd_vld   <= 1'b0;
        r_buf_cnt  <= '0;
        r_dend_vld <= 1'b0;
        if (r_state != ucaspian_pkg::ST_CLEAR) begin
          r_state      <= ucaspian_pkg::ST_CLEAR;
          r_sweep      <= '0;
          r_sweep_done <= 1'b0;
          r_clear_done <= 1'b0;
        end else if (!r_sweep_done) begin
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == '1) begin
            r_sweep_done <= 1'b1;
            r_clear_done <= 1'b1;
          end
        end
      end else if (clear_act) begin
        r_state      <= ucaspian_pkg::ST_IDLE;
        r_rd_vld     <= 1'b0;
        r_buf_cnt    <= '0;
        r_dend_vld   <= 1'b0;
        r_clear_done <= 1'b1;
      end else begin
        r_clear_done <= 1'b0;
        if (r_state == ucaspian_pkg::ST_CLEAR) r_state <= ucaspian_pkg::ST_IDLE;
        if (config_enable) begin
          case (config_byte)
            3'd1:    r_stage        <= '0;
            3'd2:    r_stage.weight <= config_value;
            3'd3:    r_stage.target <= config_value;
            default: ;
          endcase
        end
        if (w_handshake) begin
          r_state <= ucaspian_pkg::ST_WALK;
          r_cur   <= bus.syn_start;
          r_end   <= bus.syn_end;
        end else if (w_issue) begin
          if (r_cur == r_end) r_state <= ucaspian_pkg::ST_IDLE;
          else                r_cur   <= r_cur + 1'b1;
        end
        r_rd_vld <= w_issue;
        // Older buffered entries always go out before the word just read.
        if (w_out_load) begin
          if (r_buf_cnt != 2'd0) begin
            r_dend     <= r_buf[0];
            r_dend_vld <= 1'b1;
          end else if (w_land) begin
            r_dend     <= w_rd_entry;
            r_dend_vld <= 1'b1;
          end else begin
            r_dend_vld <= 1'b0;
          end
        end
        if (w_pop) r_buf[0] <= r_buf[1];
        if (w_push) begin
          if (w_wr_idx[0]) r_buf[1] <= w_rd_entry;
          else             r_buf[0] <= w_rd_entry;
        end
        r_buf_cnt <= r_buf_cnt - 2'(w_pop) + 2'(w_push);
      end
    end
  end

  assign bus.dend_vld    = r_dend_vld;
  assign bus.dend_addr   = r_dend.target;
  assign bus.dend_weight = r_dend.weight;
  assign clear_done      = r_clear_done;
  assign step_done       = r_step_done;
endmodule

// File: tb/tb_ucaspian_synapse.sv
// Directed + randomized bench for ucaspian_synapse against an array model of the synapse RAM.
module tb_ucaspian_synapse;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        clear_act;
  logic        clear_config;
  logic        clear_done;
  logic [11:0] config_addr;
  logic [7:0]  config_value;
  logic [2:0]  config_byte;
  logic        config_enable;
  logic        next_step;
  logic        step_done;

  ucaspian_synapse_if bus_if ();

  ucaspian_synapse dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .clear_act     (clear_act),
    .clear_config  (clear_config),
    .clear_done    (clear_done),
    .config_addr   (config_addr),
    .config_value  (config_value),
    .config_byte   (config_byte),
    .config_enable (config_enable),
    .next_step     (next_step),
    .step_done     (step_done),
    .bus           (bus_if)
  );

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic [7:0] mw [4096];
  logic [7:0] mt [4096];
  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int addr, input logic [7:0] w, input logic [7:0] t);
    config_enable = 1'b1; config_byte = 3'd1; tick();
    config_byte = 3'd2; config_value = w; tick();
    config_byte = 3'd3; config_value = t; config_addr = 12'(addr); tick();
    config_enable = 1'b0; config_byte = 3'd0;
    mw[addr] = w;
    mt[addr] = t;
  endtask

  // Returns just after the handshake edge.
  task automatic start_range(input int s, input int e, input string tag);
    int w;
    bus_if.syn_start = 12'(s);
    bus_if.syn_end   = 12'(e);
    bus_if.syn_vld   = 1'b1;
    #1;
    w = 0;
    while (bus_if.syn_rdy !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check($sformatf("%s_accept", tag), 32'(bus_if.syn_rdy), 32'd1);
    tick();
    bus_if.syn_vld = 1'b0;
  endtask

  // mode 0: always ready, 1: ready every third cycle, 2: random ready.
  task automatic run_range(input int s, input int e, input int mode, input bit lat_chk, input string tag);
    logic [7:0] qa[$];
    logic [7:0] qw[$];
    logic [7:0] ha, hw;
    int a, n, got, cyc;
    bit held, rdy;
    a = s;
    for (int k = 0; k < 4096; k++) begin
      if (!SKIP || mw[a] != 8'd0) begin
        qa.push_back(mt[a]);
        qw.push_back(mw[a]);
      end
      if (a == e) break;
      a = (a + 1) % 4096;
    end
    n = qa.size();
    bus_if.dend_rdy = 1'b1;
    start_range(s, e, tag);
    got = 0; cyc = 0; held = 1'b0; ha = '0; hw = '0;
    while (got < n && cyc < 300) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus_if.dend_rdy = rdy;
      if (held) begin
        check($sformatf("%s_stall_vld", tag), 32'(bus_if.dend_vld), 32'd1);
        check($sformatf("%s_stall_addr", tag), 32'(bus_if.dend_addr), 32'(ha));
        check($sformatf("%s_stall_w", tag), 32'(bus_if.dend_weight), 32'(hw));
      end
      if (bus_if.dend_vld === 1'b1) begin
        if (rdy) begin
          check($sformatf("%s_addr%0d", tag, got), 32'(bus_if.dend_addr), 32'(qa[got]));
          check($sformatf("%s_w%0d", tag, got), 32'(bus_if.dend_weight), 32'(qw[got]));
          if (lat_chk) check($sformatf("%s_cyc%0d", tag, got), 32'(cyc), 32'(2 + got));
          $display("xfer %s #%0d target=%0d weight=%0d cycle=%0d", tag, got,
                   bus_if.dend_addr, $signed(bus_if.dend_weight), cyc);
          got++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          ha = bus_if.dend_addr;
          hw = bus_if.dend_weight;
        end
      end else begin
        held = 1'b0;
      end
      tick();
      cyc++;
    end
    check($sformatf("%s_count", tag), 32'(got), 32'(n));
    bus_if.dend_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("%s_no_extra", tag), 32'(bus_if.dend_vld), 32'd0);
      tick();
    end
    check($sformatf("%s_step_done", tag), 32'(step_done), 32'd1);
  endtask

  initial begin
    int s, e, len;
    reset = 1'b0; enable = 1'b1; clear_act = 1'b0; clear_config = 1'b0;
    config_addr = '0; config_value = '0; config_byte = '0; config_enable = 1'b0;
    next_step = 1'b0;
    bus_if.syn_start = '0; bus_if.syn_end = '0; bus_if.syn_vld = 1'b0; bus_if.dend_rdy = 1'b1;
    for (int i = 0; i < 4096; i++) begin mw[i] = '0; mt[i] = '0; end

    repeat (3) tick();
    check("rst_dend_vld", 32'(bus_if.dend_vld), 32'd0);
    check("rst_dend_addr", 32'(bus_if.dend_addr), 32'd0);
    check("rst_dend_weight", 32'(bus_if.dend_weight), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_step_done", 32'(step_done), 32'd0);
    check("rst_syn_rdy", 32'(bus_if.syn_rdy), 32'd0);
    reset = 1'b1;

    // Full clear sweep
    clear_config = 1'b1;
    repeat (100) tick();
    check("sweep_mid_done", 32'(clear_done), 32'd0);
    check("sweep_syn_rdy", 32'(bus_if.syn_rdy), 32'd0);
    repeat (3997) tick();
    check("sweep_done", 32'(clear_done), 32'd1);
    clear_config = 1'b0;
    tick();
    check("sweep_done_drop", 32'(clear_done), 32'd0);
    // Reassertion restarts from 0, so it cannot be complete after 50 cycles
    clear_config = 1'b1;
    repeat (50) tick();
    check("sweep_restart", 32'(clear_done), 32'd0);
    clear_config = 1'b0;
    tick();

    run_range(12'h100, 12'h103, 0, 1'b1, "cleared");

    cfg(12'h010, 8'd5, 8'd3);
    cfg(12'h011, 8'hFE, 8'd7);
    run_range(12'h010, 12'h011, 0, 1'b1, "basic");

    cfg(12'hFFE, 8'd11, 8'd21);
    cfg(12'hFFF, 8'd12, 8'd22);
    cfg(12'h000, 8'd13, 8'd23);
    cfg(12'h001, 8'd14, 8'd24);
    run_range(12'hFFE, 12'h001, 0, 1'b1, "wrap");

    for (int k = 0; k < 8; k++) cfg(12'h040 + k, 8'(k + 1 + 16 * k), 8'($urandom_range(0, 255)));
    run_range(12'h040, 12'h047, 1, 1'b0, "stall");

    for (int it = 0; it < 6; it++) begin
      s = (it == 1) ? 4090 : $urandom_range(256, 3800);
      len = (it == 0) ? 1 : $urandom_range(2, 12);
      e = (s + len - 1) % 4096;
      for (int k = 0; k < len; k++)
        cfg((s + k) % 4096, ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
            8'($urandom_range(0, 255)));
      run_range(s, e, 2, 1'b0, $sformatf("rand%0d", it));
    end

    // clear_act mid-walk
    for (int k = 0; k < 16; k++) cfg(12'h200 + k, 8'(k + 1), 8'(k + 100));
    bus_if.dend_rdy = 1'b1;
    start_range(12'h200, 12'h20F, "cact");
    repeat (5) tick();
    check("cact_walking", 32'(bus_if.dend_vld), 32'd1);
    clear_act = 1'b1;
    tick();
    check("cact_vld", 32'(bus_if.dend_vld), 32'd0);
    check("cact_done", 32'(clear_done), 32'd1);
    clear_act = 1'b0;
    #1;
    check("cact_syn_rdy", 32'(bus_if.syn_rdy), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("cact_flushed", 32'(bus_if.dend_vld), 32'd0);
    end
    check("cact_step_done", 32'(step_done), 32'd1);

    // Reset mid-walk
    start_range(12'h200, 12'h20F, "rstw");
    repeat (4) tick();
    check("rstw_walking", 32'(bus_if.dend_vld), 32'd1);
    reset = 1'b0;
    #1;
    check("rstw_vld", 32'(bus_if.dend_vld), 32'd0);
    check("rstw_addr", 32'(bus_if.dend_addr), 32'd0);
    check("rstw_weight", 32'(bus_if.dend_weight), 32'd0);
    check("rstw_syn_rdy", 32'(bus_if.syn_rdy), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    run_range(12'h205, 12'h208, 0, 1'b1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ucaspian_synapse.md
UCASPIAN_SYNAPSE -- requirements
Module: ucaspian_synapse

Interface
- REQ-001 Parameters, one per line:
  - SYN_ADDR_W, 12, synapse index width.
  - NEURON_ADDR_W, 8, target neuron width.
  - WEIGHT_W, 8, signed weight width.
- REQ-002 Ports, one per line:
  - clk  in  1  single clock; all logic on its rising edge.
  - reset  in  1  asynchronous, active-low reset.
  - enable  in  1  when low, no new range is accepted and no new read is issued; the output holds.
  - clear_act  in  1  flushes in-flight range and buffers.
  - clear_config  in  1  zeroes synapse RAM.
  - clear_done  out  1  clear acknowledge.
  - config_addr  in  12  synapse index.
  - config_value  in  8  config byte.
  - config_byte  in  3  byte selector.
  - config_enable  in  1  config strobe.
  - next_step  in  1  time-step start (informational).
  - step_done  out  1  block idle and drained.
  - syn_start  in  12  first synapse of range.
  - syn_end  in  12  last synapse of range (inclusive).
  - syn_vld  in  1  range valid.
  - syn_rdy  out  1  range accepted.
  - dend_addr  out  8  target neuron.
  - dend_weight  out  8  signed weight.
  - dend_vld  out  1  output valid.
  - dend_rdy  in  1  dendrite ready.

Function
- REQ-003 Synapse RAM: 4096 x 16 bits; [15:8] weight (two's complement), [7:0] target neuron; 1-cycle registered read.
- REQ-004 Config writes by config_byte under config_enable:
  - 1: staging register = 0.
  - 2: staging[15:8] = value.
  - 3: staging[7:0] = value, then write staging to RAM at config_addr.
  - Other codes: ignored.
- REQ-005 States: CLEAR, IDLE, WALK.
  - IDLE -> WALK on syn_vld && syn_rdy.
  - WALK -> IDLE after the read at the end address is issued.
  - Any state -> CLEAR while clear_config is high.
  - clear_config has priority over clear_act, which has priority over config_enable, which has priority over the walk.
- REQ-006 syn_rdy = (state == IDLE) && enable && !clear_config && !clear_act; combinational; range captured on the handshake.
- REQ-007 Walk issues one read per cycle at cur, starting at cur = syn_start.
  - cur increments modulo 4096 (4095 wraps to 0).
  - The walk ends after reading syn_end; syn_end < syn_start therefore walks through the wrap.
  - syn_start == syn_end yields exactly one synapse.
- REQ-008 Latency: a handshake at cycle N gives dend_vld first at cycle N+2; sustained throughput is 1 synapse/cycle while dend_rdy = 1.
- REQ-009 Output uses a 2-entry skid buffer.
  - No read is issued when the buffer occupancy plus the reads in flight is 2 or more.
  - No output is lost or duplicated under any dend_rdy pattern.
- REQ-010 dend_addr, dend_weight and dend_vld are registered and stay stable while dend_vld && !dend_rdy.
- REQ-011 clear_act empties the buffer, drops the in-flight read, forces IDLE and dend_vld = 0, and sets clear_done = 1 on the next cycle.
- REQ-012 clear_config sweeps addresses 0..4095, writing 0 one entry per cycle; clear_done is high while clear_config is held and the sweep is complete.
  - Deasserting clear_config mid-sweep aborts the sweep and returns to IDLE.
  - A new assertion restarts the sweep at 0.
- REQ-013 step_done (registered) = IDLE && !syn_vld && buffer empty && no read in flight && !dend_vld.

Reset
- REQ-014 On reset = 0, asynchronously:
  - state = IDLE.
  - syn_rdy = 0 (while reset is low).
  - dend_vld = 0, dend_addr = 0, dend_weight = 0.
  - clear_done = 0, step_done = 0.
  - Buffer empty; cur = 0; sweep counter = 0.
- REQ-015 Reset mid-walk discards the range without emitting further outputs; RAM contents are not reset.

Configuration
- REQ-016 With UCASPIAN_SYN_SKIP_ZERO_EN defined, entries whose weight is 0 are read but not emitted: no dend_vld and no buffer slot is consumed.
- REQ-017 Without UCASPIAN_SYN_SKIP_ZERO_EN, every entry in the range is emitted, including zero weights.

Structure
- REQ-018 The shared package ucaspian_pkg holds SYN_ADDR_W, NEURON_ADDR_W, WEIGHT_W, the synapse entry struct (weight, target) and the state enum.
- REQ-019 One sub-module, dp_ram_16x4096 (one read port, one write port), holds the synapse RAM; the write port is owned by the config/clear logic and the read port by the walker.

Verification
- REQ-020 Configure 0x010 = (weight 5, target 3) and 0x011 = (weight -2, target 7); send range 0x010..0x011 with dend_rdy = 1 -> (3,5) at N+2 and (7,-2) at N+3, then step_done = 1.
- REQ-021 Range 0xFFE..0x001 -> four outputs, from addresses 0xFFE, 0xFFF, 0x000 and 0x001 in order.
- REQ-022 Range of 8 with dend_rdy toggling 1,0,0,1,... -> all 8 outputs in order, outputs stable while stalled, none dropped.
- REQ-023 clear_act during a 16-entry walk -> dend_vld = 0 next cycle, clear_done = 1, syn_rdy = 1 afterwards.
- REQ-024 clear_config held 4097 cycles -> clear_done = 1; reading any range then gives weight 0 and target 0 (zero outputs if UCASPIAN_SYN_SKIP_ZERO_EN is defined).
- REQ-025 Reset asserted mid-walk -> all outputs 0 immediately; after release, a new range is accepted.
